// File: rtl/mem_instr_sequencer.sv
// rtl/mem_instr_sequencer.sv - instruction ROM sequencer issuing read, shift and WFI commands
module mem_instr_sequencer #(
    parameter int DATA_WIDTH = 56,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_LANES  = 16,
    parameter int ITER_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [ITER_WIDTH-1:0]  NUM_ITER,
    output logic [ADDR_WIDTH-1:0]  ROM_ADDRESS,
    output logic                   ROM_ENABLE,
    input  logic [DATA_WIDTH-1:0]  ROM_DATA,
    output logic                   RD_VALID,
    input  logic                   RD_READY,
    output logic                   SH_VALID,
    input  logic                   SH_READY,
    output logic [3:0]             SH_AMOUNT,
    output logic [3*NUM_LANES-1:0] SH_LANES,
    input  logic                   GO,
    output logic                   WFI_WAIT,
    output logic [ITER_WIDTH-1:0]  ITER_COUNT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);

    localparam int LANE_W = 3 * NUM_LANES;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ISSUE = 3'd3,
        S_WFI   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ITER_WIDTH-1:0]  iter_q, iter_d;
    logic [ITER_WIDTH-1:0]  num_q, num_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  instr_q, instr_d;
    logic [ITER_WIDTH:0]    iter_inc;

    // Opcode decode on the low byte of an instruction word
    function automatic logic is_read(input logic [7:0] b);
        return b == 8'h01;
    endfunction

    function automatic logic is_shift(input logic [7:0] b);
        return b[7:4] == 4'b0101;
    endfunction

    function automatic logic is_wfi(input logic [7:0] b);
        return b[7:4] == 4'b0110;
    endfunction

    function automatic logic is_loop(input logic [7:0] b);
        return b[7:4] == 4'b0111;
    endfunction

    // State and datapath registers; reset parks in IDLE with everything cleared
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            iter_q  <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iter_q  <= iter_d;
            num_q   <= num_d;
            err_q   <= err_d;
            instr_q <= instr_d;
        end
    end

    // Next-state and datapath updates; ROM word is decoded straight off ROM_DATA in LATCH
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        iter_d   = iter_q;
        num_d    = num_q;
        err_d    = err_q;
        instr_d  = instr_q;
        iter_inc = {1'b0, iter_q} + (ITER_WIDTH + 1)'(1);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    // A zero iteration count still runs the program once
                    num_d   = (NUM_ITER == '0) ? ITER_WIDTH'(1) : NUM_ITER;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                instr_d = ROM_DATA;
                if (is_read(ROM_DATA[7:0]) || is_shift(ROM_DATA[7:0])) begin
                    state_d = S_ISSUE;
                end else if (is_wfi(ROM_DATA[7:0])) begin
                    state_d = S_WFI;
                end else if (is_loop(ROM_DATA[7:0])) begin
                    iter_d = iter_inc[ITER_WIDTH-1:0];
                    if (iter_inc >= {1'b0, num_q}) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = '0;
                        state_d = S_FETCH;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_ISSUE: begin
                // Only the ready matching the command being offered is honoured
                if ((is_read(instr_q[7:0]) && RD_READY) ||
                    (is_shift(instr_q[7:0]) && SH_READY)) begin
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            S_WFI: begin
                if (GO) begin
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so READY/GO never reach VALID combinationally
    always_comb begin
        ROM_ADDRESS = pc_q;
        ROM_ENABLE  = (state_q == S_FETCH);
        RD_VALID    = (state_q == S_ISSUE) && is_read(instr_q[7:0]);
        SH_VALID    = (state_q == S_ISSUE) && is_shift(instr_q[7:0]);
        SH_AMOUNT   = 4'd0;
        SH_LANES    = '0;
        if (SH_VALID) begin
            SH_AMOUNT = instr_q[3:0];
            SH_LANES  = instr_q[8 +: LANE_W];
        end
        WFI_WAIT    = (state_q == S_WFI);
        ITER_COUNT  = iter_q;
        BUSY        = (state_q != S_IDLE) && (state_q != S_DONE);
        DONE        = (state_q == S_DONE);
        ERR         = err_q;
    end

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// tb/tb_mem_instr_sequencer.sv - self-checking bench for mem_instr_sequencer
module tb_mem_instr_sequencer;

    localparam int DW = 56;
    localparam int AW = 6;
    localparam int NL = 16;
    localparam int IW = 16;
    localparam int LW = 3 * NL;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          START = 1'b0;
    logic [IW-1:0] NUM_ITER = '0;
    logic [AW-1:0] ROM_ADDRESS;
    logic          ROM_ENABLE;
    logic [DW-1:0] ROM_DATA;
    logic          RD_VALID;
    logic          RD_READY = 1'b0;
    logic          SH_VALID;
    logic          SH_READY = 1'b0;
    logic [3:0]    SH_AMOUNT;
    logic [LW-1:0] SH_LANES;
    logic          GO = 1'b0;
    logic          WFI_WAIT;
    logic [IW-1:0] ITER_COUNT;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    mem_instr_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LANES(NL), .ITER_WIDTH(IW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .NUM_ITER(NUM_ITER),
        .ROM_ADDRESS(ROM_ADDRESS), .ROM_ENABLE(ROM_ENABLE), .ROM_DATA(ROM_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .SH_VALID(SH_VALID), .SH_READY(SH_READY),
        .SH_AMOUNT(SH_AMOUNT), .SH_LANES(SH_LANES),
        .GO(GO), .WFI_WAIT(WFI_WAIT), .ITER_COUNT(ITER_COUNT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Registered ROM: data appears the cycle after the enable
    logic [DW-1:0] rom [0:63];
    always @(posedge CLK) if (ROM_ENABLE) ROM_DATA <= rom[ROM_ADDRESS];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Handshake monitor and hold-stability watcher
    int            rd_cyc[$];
    int            sh_cyc[$];
    logic [51:0]   sh_log[$];
    int            stab_bad = 0;
    logic          sh_hold = 1'b0;
    logic          rd_hold = 1'b0;
    logic          ren_prev = 1'b0;
    logic [51:0]   sh_prev = '0;

    always @(negedge CLK) begin
        if (RESET) begin
            sh_hold  <= 1'b0;
            rd_hold  <= 1'b0;
            ren_prev <= 1'b0;
        end else begin
            if (RD_VALID && RD_READY) rd_cyc.push_back(cyc);
            if (SH_VALID && SH_READY) begin
                sh_cyc.push_back(cyc);
                sh_log.push_back({SH_AMOUNT, SH_LANES});
            end
            if (sh_hold && !(SH_VALID && ({SH_AMOUNT, SH_LANES} == sh_prev))) stab_bad <= stab_bad + 1;
            if (rd_hold && !RD_VALID) stab_bad <= stab_bad + 1;
            if (ROM_ENABLE && ren_prev) stab_bad <= stab_bad + 1;
            sh_hold  <= SH_VALID && !SH_READY;
            rd_hold  <= RD_VALID && !RD_READY;
            sh_prev  <= {SH_AMOUNT, SH_LANES};
            ren_prev <= ROM_ENABLE;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_shift(input logic [3:0] amt, input logic [LW-1:0] ln);
        return {ln, 4'h5, amt};
    endfunction

    function automatic logic legal(input logic [7:0] b);
        return (b == 8'h01) || (b[7:4] == 4'h5) || (b[7:4] == 4'h6) || (b[7:4] == 4'h7);
    endfunction

    task automatic load(input logic [DW-1:0] i0, input logic [DW-1:0] i1,
                        input logic [DW-1:0] i2, input logic [DW-1:0] i3);
        for (int a = 0; a < 64; a++) rom[a] = 56'h90;
        rom[0] = i0; rom[1] = i1; rom[2] = i2; rom[3] = i3;
    endtask

    // Starts the program and waits for DONE; drel is the DONE cycle counted from the START cycle
    task automatic run_prog(input logic [IW-1:0] n, input bit rnd, input int budget,
                            output int t0, output int drel);
        rd_cyc.delete(); sh_cyc.delete(); sh_log.delete();
        NUM_ITER = n;
        t0 = cyc;
        START = 1'b1;
        tick();
        START = 1'b0;
        NUM_ITER = 16'hFFFF;
        check("start_fetch", {ERR, BUSY, ROM_ENABLE, ROM_ADDRESS}, {1'b0, 1'b1, 1'b1, 6'd0});
        drel = -1;
        for (int c = 0; c < budget; c++) begin
            if (DONE) begin
                drel = cyc - t0;
                break;
            end
            if (rnd) begin
                RD_READY = 1'($urandom_range(0, 1));
                SH_READY = 1'($urandom_range(0, 1));
                GO       = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
    endtask

    // Program-level reference: walk the ROM as an interpreter and list the commands it must issue
    logic [51:0] exp_sh[$];
    task automatic ref_model(input logic [IW-1:0] n, output int rd, output int it, output int er);
        int eff;
        int pc;
        logic [DW-1:0] w;
        eff = (n == 0) ? 1 : int'(n);
        pc = 0; it = 0; er = 0; rd = 0;
        exp_sh.delete();
        for (int step = 0; step < 10000; step++) begin
            w = rom[pc];
            if (w[7:0] == 8'h01) begin
                rd++;
                pc = (pc + 1) % 64;
            end else if (w[7:4] == 4'h5) begin
                exp_sh.push_back({w[3:0], w[55:8]});
                pc = (pc + 1) % 64;
            end else if (w[7:4] == 4'h6) begin
                pc = (pc + 1) % 64;
            end else if (w[7:4] == 4'h7) begin
                it++;
                if (it >= eff) break;
                pc = 0;
            end else begin
                er = 1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [DW-1:0] i0, i1, i2, i3;
        logic [IW-1:0] n;
        int rd, sh, it, er, dc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd_i, sh_a, lp_i, wf_i, sh_s;
        logic [LW-1:0] ln;
        logic [51:0]   exp_stall;
        int t0, drel, w0, stab0, erd, eit, eer, len, nsh, ok;
        logic [7:0]    b;
        logic [IW-1:0] n;

        rd_i = 56'h01;
        lp_i = 56'h70;
        wf_i = 56'h60;
        sh_a = mk_shift(4'hF, 48'h4920);
        tbl[0] = '{rd_i, sh_a, lp_i, 56'h90, 16'd1, 1, 1, 1, 0, 9};
        tbl[1] = '{rd_i, sh_a, lp_i, 56'h90, 16'd3, 3, 3, 3, 0, 25};
        tbl[2] = '{rd_i, sh_a, lp_i, 56'h90, 16'd0, 1, 1, 1, 0, 9};
        tbl[3] = '{56'h90, rd_i, lp_i, 56'h90, 16'd2, 0, 0, 0, 1, 3};
        tbl[4] = '{rd_i, wf_i, sh_a, lp_i, 16'd2, 2, 2, 2, 0, 23};
        tbl[5] = '{lp_i, rd_i, rd_i, rd_i, 16'd4, 0, 0, 4, 0, 9};
        tbl[6] = '{rd_i, 56'h02, lp_i, 56'h90, 16'd1, 1, 0, 0, 1, 6};

        load(56'h90, 56'h90, 56'h90, 56'h90);
        tick(); tick();
        RESET = 1'b0;
        tick();
        check("reset_outs", {ROM_ADDRESS, ROM_ENABLE, RD_VALID, SH_VALID, SH_AMOUNT, WFI_WAIT,
                             ITER_COUNT, BUSY, DONE, ERR}, 64'd0);
        check("reset_lanes", SH_LANES, 64'd0);

        // Table: ready and GO held high
        RD_READY = 1'b1; SH_READY = 1'b1; GO = 1'b1;
        for (int k = 0; k < 7; k++) begin
            load(tbl[k].i0, tbl[k].i1, tbl[k].i2, tbl[k].i3);
            run_prog(tbl[k].n, 1'b0, 200, t0, drel);
            check($sformatf("tbl%0d_done_cycle", k), drel, tbl[k].dc);
            check($sformatf("tbl%0d_reads", k), rd_cyc.size(), tbl[k].rd);
            check($sformatf("tbl%0d_shifts", k), sh_cyc.size(), tbl[k].sh);
            check($sformatf("tbl%0d_iter", k), ITER_COUNT, tbl[k].it);
            check($sformatf("tbl%0d_err", k), ERR, tbl[k].er);
            check($sformatf("tbl%0d_busy", k), BUSY, 0);
        end

        // Exact command timing for READ, SHIFT, LOOP
        load(rd_i, sh_a, lp_i, 56'h90);
        run_prog(16'd1, 1'b0, 200, t0, drel);
        check("rd_cycle", (rd_cyc.size() > 0) ? rd_cyc[0] - t0 : -1, 3);
        check("sh_cycle", (sh_cyc.size() > 0) ? sh_cyc[0] - t0 : -1, 6);
        check("sh_amt_lanes", (sh_log.size() > 0) ? sh_log[0] : 52'd0, {4'hF, 48'h4920});

        // SH_READY stalled five cycles in ISSUE
        ln = {16'($urandom()), 32'($urandom())};
        load(mk_shift(4'h9, ln), lp_i, 56'h90, 56'h90);
        exp_stall = {4'h9, ln};
        SH_READY = 1'b0;
        stab0 = stab_bad;
        rd_cyc.delete(); sh_cyc.delete(); sh_log.delete();
        NUM_ITER = 16'd1; START = 1'b1; tick(); START = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {SH_VALID, ROM_ADDRESS, SH_AMOUNT, SH_LANES}, {1'b1, 6'd0, exp_stall});
            tick();
        end
        SH_READY = 1'b1;
        check("stall_release", {SH_VALID, ROM_ADDRESS}, {1'b1, 6'd0});
        tick();
        check("stall_after", {SH_VALID, ROM_ENABLE, ROM_ADDRESS}, {1'b0, 1'b1, 6'd1});
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            if (DONE) ok = 1; else tick();
        end
        check("stall_done", ok, 1);
        check("stall_shifts", sh_cyc.size(), 1);
        check("stall_stable", stab_bad - stab0, 0);

        // WFI: early GO during ISSUE is ignored, late GO resumes at PC 2
        load(rd_i, wf_i, sh_a, lp_i);
        RD_READY = 1'b0; SH_READY = 1'b1; GO = 1'b0;
        rd_cyc.delete(); sh_cyc.delete(); sh_log.delete();
        NUM_ITER = 16'd1; START = 1'b1; tick(); START = 1'b0;
        tick(); tick();
        GO = 1'b1;
        tick();
        GO = 1'b0;
        check("wfi_early_go", {RD_VALID, WFI_WAIT}, {1'b1, 1'b0});
        RD_READY = 1'b1;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (WFI_WAIT) ok = 1; else tick();
        end
        check("wfi_entered", ok, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wfi_parked", {WFI_WAIT, ROM_ENABLE}, {1'b1, 1'b0});
        end
        GO = 1'b1;
        tick();
        GO = 1'b0;
        check("wfi_resume", {WFI_WAIT, ROM_ENABLE, ROM_ADDRESS}, {1'b0, 1'b1, 6'd2});
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            if (DONE) ok = 1; else tick();
        end
        check("wfi_done", ok, 1);
        check("wfi_cmds", {rd_cyc.size(), sh_cyc.size()}, {32'd1, 32'd1});

        // RESET while RD_VALID is waiting
        load(rd_i, lp_i, 56'h90, 56'h90);
        RD_READY = 1'b0;
        NUM_ITER = 16'd1; START = 1'b1; tick(); START = 1'b0;
        tick(); tick();
        check("rst_pre_valid", RD_VALID, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst_outs", {ROM_ADDRESS, ROM_ENABLE, RD_VALID, SH_VALID, SH_AMOUNT, WFI_WAIT,
                           ITER_COUNT, BUSY, DONE, ERR}, 64'd0);
        RD_READY = 1'b1;
        tick();
        check("rst_idle", {RD_VALID, BUSY, ROM_ENABLE}, 64'd0);
        run_prog(16'd1, 1'b0, 100, t0, drel);
        check("rst_restart_done", drel, 6);
        check("rst_restart_reads", rd_cyc.size(), 1);

        // Random programs with random ready/GO against the interpreter model
        for (int r = 0; r < 25; r++) begin
            for (int a = 0; a < 64; a++) rom[a] = 56'h90;
            len = $urandom_range(1, 6);
            for (int p = 0; p < len; p++) begin
                ln = {16'($urandom()), 32'($urandom())};
                case ($urandom_range(0, 9))
                    0: begin
                        do b = 8'($urandom_range(0, 255)); while (legal(b));
                        rom[p] = {ln, b};
                    end
                    1, 2:    rom[p] = {ln, 4'h6, 4'($urandom())};
                    3, 4, 5: rom[p] = {ln, 8'h01};
                    default: rom[p] = mk_shift(4'($urandom()), ln);
                endcase
            end
            rom[len] = {48'($urandom()), 4'h7, 4'($urandom())};
            n = 16'($urandom_range(0, 3));
            ref_model(n, erd, eit, eer);
            stab0 = stab_bad;
            run_prog(n, 1'b1, 3000, t0, drel);
            check("rnd_done", drel >= 0, 1);
            check("rnd_reads", rd_cyc.size(), erd);
            check("rnd_shifts", sh_log.size(), exp_sh.size());
            nsh = (sh_log.size() < exp_sh.size()) ? sh_log.size() : exp_sh.size();
            for (int s = 0; s < nsh; s++) check("rnd_shift_word", sh_log[s], exp_sh[s]);
            check("rnd_iter", ITER_COUNT, eit);
            check("rnd_err", ERR, eer);
            check("rnd_stable", stab_bad - stab0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
